// File: rtl/perf_pkg.sv
// Shared constants and types for the cache performance counter CSR reader.
// Counter map: 0 = L1I access, 1 = L1I miss, 2 = L1D access, 3 = L1D miss.
package perf_pkg;

    localparam int NUM_CNT = 4;
    localparam int IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

    localparam logic [11:0] CSR_LO_BASE = 12'hB03;
    localparam logic [11:0] CSR_HI_BASE = 12'hB83;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } perf_rd_state_e;

    typedef struct packed {
        logic             hit_lo;
        logic             hit_hi;
        logic [IDX_W-1:0] idx;
    } perf_dec_t;

endpackage

// File: rtl/perf_csr_decode.sv
// Combinational CSR address decode into a low/high hit and counter index.
// Ranges are found by unsigned 12-bit subtraction, so addresses below a base wrap high and miss.
module perf_csr_decode #(
    parameter int          NUM_CNT     = perf_pkg::NUM_CNT,
    parameter logic [11:0] CSR_LO_BASE = perf_pkg::CSR_LO_BASE,
    parameter logic [11:0] CSR_HI_BASE = perf_pkg::CSR_HI_BASE
) (
    input  logic [11:0]         addr,
    output perf_pkg::perf_dec_t dec
);
    import perf_pkg::*;

    localparam logic [11:0] CNT_LIM = 12'(NUM_CNT);

    logic [11:0] off_lo;
    logic [11:0] off_hi;
    logic        in_lo;
    logic        in_hi;

    assign off_lo = addr - CSR_LO_BASE;
    assign off_hi = addr - CSR_HI_BASE;
    assign in_lo  = (off_lo < CNT_LIM);
    assign in_hi  = (off_hi < CNT_LIM);

    always_comb begin
        dec        = '0;
        dec.hit_lo = in_lo;
        dec.hit_hi = in_hi && !in_lo;
        if (in_lo) begin
            dec.idx = off_lo[IDX_W-1:0];
        end else if (in_hi) begin
            dec.idx = off_hi[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/perf_counter_reader.sv
// CSR read responder for the 64-bit cache performance counters, one read outstanding.
// Optional PERF_SNAPSHOT_EN: a low read latches the high word so the following high read is carry-atomic.
module perf_counter_reader #(
    parameter int          NUM_CNT     = perf_pkg::NUM_CNT,
    parameter logic [11:0] CSR_LO_BASE = perf_pkg::CSR_LO_BASE,
    parameter logic [11:0] CSR_HI_BASE = perf_pkg::CSR_HI_BASE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CNT*64-1:0] cnt_in,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [11:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_err
);
    import perf_pkg::*;

    perf_rd_state_e state;
    perf_dec_t      dec;
    logic [63:0]    cnt_w [NUM_CNT];
    logic           req_fire;
    logic           resp_fire;
    logic [31:0]    rd_data;
    logic           rd_err;
    logic [31:0]    resp_data_q;
    logic           resp_err_q;

`ifdef PERF_SNAPSHOT_EN
    logic [31:0]        snap_hi [NUM_CNT];
    logic [NUM_CNT-1:0] snap_vld;
`endif

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        assign cnt_w[i] = cnt_in[64*i +: 64];
    end

    perf_csr_decode #(
        .NUM_CNT     (NUM_CNT),
        .CSR_LO_BASE (CSR_LO_BASE),
        .CSR_HI_BASE (CSR_HI_BASE)
    ) u_decode (
        .addr (req_addr),
        .dec  (dec)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign req_fire   = req_valid && req_ready;
    assign resp_fire  = resp_valid && resp_ready;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (dec.hit_lo) begin
            rd_data = cnt_w[dec.idx][31:0];
        end else if (dec.hit_hi) begin
`ifdef PERF_SNAPSHOT_EN
            rd_data = snap_vld[dec.idx] ? snap_hi[dec.idx] : cnt_w[dec.idx][63:32];
`else
            rd_data = cnt_w[dec.idx][63:32];
`endif
        end else begin
            rd_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (req_fire)  state <= RESP;
                RESP:    if (resp_fire) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Response registers load only at accept, so they hold through any back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else if (req_fire) begin
            resp_data_q <= rd_data;
            resp_err_q  <= rd_err;
        end
    end

`ifdef PERF_SNAPSHOT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap_hi[i] <= '0;
            end
            snap_vld <= '0;
        end else if (req_fire && dec.hit_lo) begin
            snap_hi[dec.idx]  <= cnt_w[dec.idx][63:32];
            snap_vld[dec.idx] <= 1'b1;
        end else if (req_fire && dec.hit_hi) begin
            snap_vld[dec.idx] <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_perf_counter_reader.sv
// Self-checking bench for perf_counter_reader: vector table, directed corner sequences and
// randomized reads against a reference model of the counter map and snapshot rules.
module tb_perf_counter_reader;

    logic         clk;
    logic         rst;
    logic [255:0] cnt_in;
    logic         req_valid;
    logic         req_ready;
    logic [11:0]  req_addr;
    logic         resp_valid;
    logic         resp_ready;
    logic [31:0]  resp_data;
    logic         resp_err;

    logic [63:0]  cnt_v [4];

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PERF_SNAPSHOT_EN
    logic [31:0] m_snap     [4];
    bit          m_snap_vld [4];
`endif

    assign cnt_in = {cnt_v[3], cnt_v[2], cnt_v[1], cnt_v[0]};

    perf_counter_reader dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
`ifdef PERF_SNAPSHOT_EN
        for (int i = 0; i < 4; i++) begin
            m_snap[i]     = '0;
            m_snap_vld[i] = 1'b0;
        end
`endif
    endfunction

    // Expected {err, data} for a read issued with the current counter values.
    function automatic logic [32:0] model_read(input logic [11:0] addr);
        int a;
        int lo_off;
        int hi_off;
        a      = int'(addr);
        lo_off = a - 'hB03;
        hi_off = a - 'hB83;
        if (lo_off >= 0 && lo_off < 4) begin
`ifdef PERF_SNAPSHOT_EN
            m_snap[lo_off]     = cnt_v[lo_off][63:32];
            m_snap_vld[lo_off] = 1'b1;
`endif
            return {1'b0, cnt_v[lo_off][31:0]};
        end
        if (hi_off >= 0 && hi_off < 4) begin
`ifdef PERF_SNAPSHOT_EN
            if (m_snap_vld[hi_off]) begin
                m_snap_vld[hi_off] = 1'b0;
                return {1'b0, m_snap[hi_off]};
            end
`endif
            return {1'b0, cnt_v[hi_off][63:32]};
        end
        return {1'b1, 32'h0};
    endfunction

    // One read: accept on the next edge, hold resp_ready low for 'stall' cycles, then complete.
    task automatic rd(input logic [11:0] addr, input int stall,
                      output logic [31:0] d, output logic e);
        @(negedge clk);
        req_addr   = addr;
        req_valid  = 1'b1;
        resp_ready = (stall == 0);
        chk("req_ready_before", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("resp_valid_latency", {63'd0, resp_valid}, 64'd1);
        d = resp_data;
        e = resp_err;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", {63'd0, resp_valid}, 64'd1);
            chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
            chk("stall_data", {32'd0, resp_data}, {32'd0, d});
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_valid", {63'd0, resp_valid}, 64'd0);
        chk("post_hs_ready", {63'd0, req_ready}, 64'd1);
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t        vec [11];
    logic [31:0] d;
    logic        e;
    logic [32:0] m;
    logic [31:0] hold_d;

    initial begin
        vec[0]  = '{12'hB03, 32'h5000_0000, 1'b0};
        vec[1]  = '{12'hB04, 32'h5000_0001, 1'b0};
        vec[2]  = '{12'hB06, 32'h5000_0003, 1'b0};
        vec[3]  = '{12'hB83, 32'hA000_0000, 1'b0};
        vec[4]  = '{12'hB86, 32'hA000_0003, 1'b0};
        vec[5]  = '{12'hB07, 32'h0,         1'b1};
        vec[6]  = '{12'hB02, 32'h0,         1'b1};
        vec[7]  = '{12'hB82, 32'h0,         1'b1};
        vec[8]  = '{12'hB87, 32'h0,         1'b1};
        vec[9]  = '{12'hFFF, 32'h0,         1'b1};
        vec[10] = '{12'h000, 32'h0,         1'b1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) cnt_v[i] = '0;
        model_reset();
        #12;
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset_resp_data", {32'd0, resp_data}, 64'd0);
        chk("reset_resp_err", {63'd0, resp_err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table with a fixed counter pattern.
        for (int i = 0; i < 4; i++) begin
            cnt_v[i] = {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)};
        end
        for (int k = 0; k < 11; k++) begin
            m = model_read(vec[k].addr);
            rd(vec[k].addr, 0, d, e);
            chk($sformatf("vec%0d_data", k), {32'd0, d}, {32'd0, vec[k].exp_data});
            chk($sformatf("vec%0d_err", k), {63'd0, e}, {63'd0, vec[k].exp_err});
        end

        // Low read of counter 1.
        cnt_v[1] = 64'h0000_0002_0000_0010;
        m = model_read(12'hB04);
        rd(12'hB04, 0, d, e);
        chk("low_cnt1_data", {32'd0, d}, 64'h10);
        chk("low_cnt1_err", {63'd0, e}, 64'd0);

        // Low/high pair across a 32-bit carry.
        cnt_v[0] = 64'h0000_0000_FFFF_FFFF;
        m = model_read(12'hB03);
        rd(12'hB03, 0, d, e);
        chk("carry_lo", {32'd0, d}, 64'hFFFF_FFFF);
        cnt_v[0] = 64'h0000_0001_0000_0000;
        m = model_read(12'hB83);
        rd(12'hB83, 0, d, e);
`ifdef PERF_SNAPSHOT_EN
        chk("carry_hi_snap", {32'd0, d}, 64'h0);
`else
        chk("carry_hi_live", {32'd0, d}, 64'h1);
`endif

        // Bad address completes with an error.
        m = model_read(12'hB10);
        rd(12'hB10, 0, d, e);
        chk("bad_addr_err", {63'd0, e}, 64'd1);
        chk("bad_addr_data", {32'd0, d}, 64'd0);

        // Back-pressure: counter moves during the stall, response must not.
        cnt_v[2] = 64'h1234_5678_9ABC_DEF0;
        m = model_read(12'hB05);
        @(negedge clk);
        req_addr   = 12'hB05;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cnt_v[2]  = 64'h0;
        hold_d    = resp_data;
        chk("bp_first_data", {32'd0, hold_d}, 64'h9ABC_DEF0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
            chk("bp_data", {32'd0, resp_data}, 64'h9ABC_DEF0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", {63'd0, resp_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, req_ready}, 64'd1);

        // Reset while a low-read response is stalled drops it and clears any snapshot.
        cnt_v[0] = 64'h0000_0007_0000_0001;
        @(negedge clk);
        req_addr   = 12'hB03;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rst_pre_valid", {63'd0, resp_valid}, 64'd1);
        chk("rst_pre_data", {32'd0, resp_data}, 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_async_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_async_data", {32'd0, resp_data}, 64'd0);
        chk("rst_async_err", {63'd0, resp_err}, 64'd0);
        model_reset();
        @(negedge clk);
        rst        = 1'b0;
        resp_ready = 1'b1;
        cnt_v[0]   = 64'h0000_0009_0000_0001;
        m = model_read(12'hB83);
        rd(12'hB83, 0, d, e);
        chk("rst_hi_live", {32'd0, d}, 64'h9);

        // Randomized reads against the model, with counters ticking between reads.
        for (int it = 0; it < 300; it++) begin
            int          sel;
            int          ci;
            logic [11:0] a;
            sel = int'($urandom_range(0, 3));
            ci  = int'($urandom_range(0, 3));
            case (sel)
                0:       a = 12'hB03 + 12'(ci);
                1:       a = 12'hB83 + 12'(ci);
                2:       a = 12'hB00 + 12'($urandom_range(0, 15));
                default: a = 12'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) begin
                cnt_v[ci] = {32'($urandom), 32'hFFFF_FFFF - 32'($urandom_range(0, 2))};
            end
            m = model_read(a);
            rd(a, int'($urandom_range(0, 2)), d, e);
            chk($sformatf("rand%0d_data_a%0h", it, a), {32'd0, d}, {32'd0, m[31:0]});
            chk($sformatf("rand%0d_err_a%0h", it, a), {63'd0, e}, {63'd0, m[32]});
            for (int i = 0; i < 4; i++) begin
                cnt_v[i] = cnt_v[i] + 64'($urandom_range(0, 3));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
